// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader: streams NUM_IO config words (word NUM_IO-1 first, MSB first) onto a gpio serial chain, then pulses the latch.
// Define GPIO_LOADER_AUTOSTART_EN to launch one load automatically after every reset release.
module gpio_serial_loader #(
   parameter int  NUM_IO        = 19,
   parameter int  PAD_CTRL_BITS = 10,
   localparam int AW            = (NUM_IO > 1) ? $clog2(NUM_IO) : 1,
   localparam int CW            = $clog2(PAD_CTRL_BITS)
) (
   input  logic                     serial_clock,
   input  logic                     resetn,
   input  logic                     start,
   output logic [AW-1:0]            cfg_raddr,
   output logic                     cfg_rd,
   input  logic [PAD_CTRL_BITS-1:0] cfg_rdata,
   output logic                     serial_data_out,
   output logic                     serial_load_out,
   output logic                     busy,
   output logic                     done
);
   typedef enum logic [1:0] {IDLE, FETCH, SHIFT, LOAD} state_t;
   state_t                   state_q, state_d;
   logic [AW-1:0]            raddr_q, raddr_d, word_q, word_d;
   logic                     rd_q, rd_d, done_q, done_d, sdo_q, load_q, go;
   logic [PAD_CTRL_BITS-1:0] tx_q, tx_d;
   logic [CW-1:0]            cnt_q, cnt_d;
`ifdef GPIO_LOADER_AUTOSTART_EN
   logic auto_q;
   always_ff @(posedge serial_clock or negedge resetn)
      if (!resetn) auto_q <= 1'b1;
      else auto_q <= 1'b0;
   assign go = start | auto_q;
`else
   assign go = start;
`endif
   always_ff @(posedge serial_clock or negedge resetn)
      if (!resetn) begin
         state_q <= IDLE;
         raddr_q <= '0;
         word_q  <= '0;
         rd_q    <= 1'b0;
         done_q  <= 1'b0;
         tx_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         raddr_q <= raddr_d;
         word_q  <= word_d;
         rd_q    <= rd_d;
         done_q  <= done_d;
         tx_q    <= tx_d;
         cnt_q   <= cnt_d;
      end
   always_comb begin
      state_d = state_q;
      raddr_d = raddr_q;
      word_d  = word_q;
      rd_d    = 1'b0;
      done_d  = 1'b0;
      tx_d    = tx_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (go) begin
            state_d = FETCH;
            raddr_d = AW'(NUM_IO - 1);
            word_d  = AW'(NUM_IO - 1);
            rd_d    = 1'b1;
         end
         FETCH: begin
            tx_d    = cfg_rdata;
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            tx_d  = {tx_q[PAD_CTRL_BITS-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            // prefetch one cycle early so the next word is ready exactly at the word boundary
            if (cnt_q == CW'(PAD_CTRL_BITS - 2) && word_q != '0) begin
               raddr_d = raddr_q - 1'b1;
               rd_d    = 1'b1;
            end
            if (cnt_q == CW'(PAD_CTRL_BITS - 1)) begin
               cnt_d = '0;
               if (word_q == '0) state_d = LOAD;
               else begin
                  tx_d   = cfg_rdata;
                  word_d = word_q - 1'b1;
               end
            end
         end
         LOAD: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      endcase
   end
   // chain outputs move on the falling edge so downstream sees them stable at every rising edge
   always_ff @(negedge serial_clock or negedge resetn)
      if (!resetn) begin
         sdo_q  <= 1'b0;
         load_q <= 1'b0;
      end else begin
         sdo_q  <= (state_q == SHIFT) & tx_q[PAD_CTRL_BITS-1];
         load_q <= state_q == LOAD;
      end
   assign cfg_raddr       = raddr_q;
   assign cfg_rd          = rd_q;
   assign serial_data_out = sdo_q;
   assign serial_load_out = load_q;
   assign busy            = state_q != IDLE;
   assign done            = done_q;
endmodule

// File: tb/tb_gpio_serial_loader.sv
// tb_gpio_serial_loader: scoreboard bench with a model serial chain behind a 19-block and a 2-block loader.
module tb_gpio_serial_loader;
   localparam int NB = 19, NS = 2, P = 10, LB = NB * P, LS = NS * P;
`ifdef GPIO_LOADER_AUTOSTART_EN
   localparam int AUTO = 1;
`else
   localparam int AUTO = 0;
`endif
   logic clk = 1'b0, resetn = 1'b0, start_b = 1'b0, start_s = 1'b0;
   logic [4:0] raddr_b;
   logic [0:0] raddr_s;
   logic rd_b, rd_s, sdo_b, sdo_s, ld_b, ld_s, busy_b, busy_s, done_b, done_s;
   logic [P-1:0] mem_b [NB];
   logic [P-1:0] mem_s [NS];
   logic [P-1:0] rdata_b = '0, rdata_s = '0;
   logic [LB-1:0] chain_b = '0, latch_b = '0;
   logic [LS-1:0] chain_s = '0, latch_s = '0;
   logic [LB-1:0] exp_b [$];
   logic [4:0] rd_log_b [$];
   int n_chk = 0, n_fail = 0, ld_pulses_b = 0, ld_pulses_s = 0, edge_bad = 0, ld_bad = 0;
   time rise_b = 0, rise_s = 0;

   always #5 clk = ~clk;

   gpio_serial_loader #(.NUM_IO(NB), .PAD_CTRL_BITS(P)) u_big (
      .serial_clock(clk), .resetn(resetn), .start(start_b), .cfg_raddr(raddr_b), .cfg_rd(rd_b),
      .cfg_rdata(rdata_b), .serial_data_out(sdo_b), .serial_load_out(ld_b), .busy(busy_b), .done(done_b));
   gpio_serial_loader #(.NUM_IO(NS), .PAD_CTRL_BITS(P)) u_small (
      .serial_clock(clk), .resetn(resetn), .start(start_s), .cfg_raddr(raddr_s), .cfg_rd(rd_s),
      .cfg_rdata(rdata_s), .serial_data_out(sdo_s), .serial_load_out(ld_s), .busy(busy_s), .done(done_s));

   // config memory answers a strobe in time for the following rising edge
   always @(negedge clk) begin
      if (rd_b && raddr_b < 5'(NB)) rdata_b <= mem_b[raddr_b];
      if (rd_s) rdata_s <= mem_s[raddr_s];
   end
   always @(posedge clk) begin
      chain_b <= {chain_b[LB-2:0], sdo_b};
      chain_s <= {chain_s[LS-2:0], sdo_s};
      if (rd_b) rd_log_b.push_back(raddr_b);
   end
   always @(posedge ld_b) begin latch_b = chain_b; ld_pulses_b++; rise_b = $time; end
   always @(posedge ld_s) begin latch_s = chain_s; ld_pulses_s++; rise_s = $time; end
   always @(negedge ld_b) if ($time - rise_b != 10) ld_bad++;
   always @(negedge ld_s) if ($time - rise_s != 10) ld_bad++;
   always @(sdo_b or ld_b or sdo_s or ld_s) if (clk) edge_bad++;

   function automatic logic [LB-1:0] img_b();
      logic [LB-1:0] v;
      for (int k = 0; k < NB; k++) v[k*P +: P] = mem_b[k];
      return v;
   endfunction

   task automatic fill_push();
      foreach (mem_b[k]) mem_b[k] = P'($urandom);
      exp_b.push_back(img_b());
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_chk++;
      if ({sdo_b, ld_b, busy_b, done_b, rd_b, raddr_b} !== '0) begin
         n_fail++; $display("FAIL reset_big: outputs %b, required all 0", {sdo_b, ld_b, busy_b, done_b, rd_b, raddr_b});
      end
      n_chk++;
      if ({sdo_s, ld_s, busy_s, done_s, rd_s, raddr_s} !== '0) begin
         n_fail++; $display("FAIL reset_small: outputs %b, required all 0", {sdo_s, ld_s, busy_s, done_s, rd_s, raddr_s});
      end
   endtask

   task automatic test_autostart();
      int pb = ld_pulses_b, ps = ld_pulses_s;
      @(negedge clk);
      #2 resetn = 1'b1;
      repeat (LB + 60) @(negedge clk);
      n_chk++;
      if (ld_pulses_b - pb != AUTO) begin
         n_fail++; $display("FAIL autostart_big: %0d loads after reset, required %0d", ld_pulses_b - pb, AUTO);
      end
      n_chk++;
      if (ld_pulses_s - ps != AUTO) begin
         n_fail++; $display("FAIL autostart_small: %0d loads after reset, required %0d", ld_pulses_s - ps, AUTO);
      end
`ifdef GPIO_LOADER_AUTOSTART_EN
      n_chk++;
      if (latch_b !== img_b()) begin
         n_fail++; $display("FAIL autostart_latch: got %h, required %h", latch_b, img_b());
      end
`endif
   endtask

   task automatic test_basic_small();
      int cyc = 0;
      logic [LS-1:0] exp = {10'h3FF, 10'h001};
      @(negedge clk);
      start_s = 1'b1;
      do begin
         @(posedge clk); #1; cyc++;
         start_s = 1'b0;
      end while (!done_s && cyc < LS + 20);
      n_chk++;
      if (cyc != LS + 3) begin
         n_fail++; $display("FAIL small_latency: done after %0d edges, required %0d", cyc, LS + 3);
      end
      n_chk++;
      if (latch_s !== exp) begin
         n_fail++; $display("FAIL small_latch: got %h, required %h", latch_s, exp);
      end
      @(posedge clk); #1;
      n_chk++;
      if (done_s !== 1'b0) begin
         n_fail++; $display("FAIL small_done_pulse: done %b one cycle later, required 0", done_s);
      end
   endtask

   task automatic run_big(input string name, input int poke, input bit chain);
      int cyc = 0, bad = 0, p0 = ld_pulses_b, base = rd_log_b.size();
      logic [LB-1:0] exp;
      if (!start_b) begin @(negedge clk); start_b = 1'b1; end
      do begin
         @(posedge clk); #1; cyc++;
         start_b = (cyc == poke);
      end while (!done_b && cyc < LB + 20);
      start_b = chain;
      n_chk++;
      if (cyc != LB + 3) begin
         n_fail++; $display("FAIL %s_latency: done after %0d edges, required %0d", name, cyc, LB + 3);
      end
      exp = exp_b.pop_front();
      n_chk++;
      if (latch_b !== exp) begin
         n_fail++; $display("FAIL %s_latch: got %h, required %h", name, latch_b, exp);
      end
      n_chk++;
      if (ld_pulses_b - p0 != 1) begin
         n_fail++; $display("FAIL %s_loads: %0d load pulses, required 1", name, ld_pulses_b - p0);
      end
      for (int i = 0; i < NB; i++)
         if (base + i >= rd_log_b.size() || rd_log_b[base + i] != 5'(NB - 1 - i)) bad++;
      n_chk++;
      if (bad != 0 || rd_log_b.size() - base != NB) begin
         n_fail++; $display("FAIL %s_raddr_seq: %0d reads with %0d out of order, required %0d reads %0d..0", name, rd_log_b.size() - base, bad, NB, NB - 1);
      end
      if (!chain) begin
         @(posedge clk); #1;
         n_chk++;
         if ({done_b, busy_b} !== 2'b00) begin
            n_fail++; $display("FAIL %s_done_pulse: done/busy %b%b one cycle later, required 00", name, done_b, busy_b);
         end
      end
   endtask

   task automatic test_random();
      fill_push(); run_big("rand1", 0, 1'b0);
      fill_push(); run_big("rand2", 0, 1'b0);
   endtask

   task automatic test_start_ignored();
      fill_push(); run_big("busy_start", 40, 1'b0);
   endtask

   task automatic test_back_to_back();
      fill_push(); run_big("b2b_first", 0, 1'b1);
      fill_push(); run_big("b2b_second", 0, 1'b0);
   endtask

   task automatic test_abort();
      int cyc = 0, p0 = ld_pulses_b;
      foreach (mem_b[k]) mem_b[k] = P'($urandom);
      @(negedge clk);
      start_b = 1'b1;
      do begin
         @(posedge clk); #1; cyc++;
         start_b = 1'b0;
      end while (cyc < 60);
      @(negedge clk); #2;
      n_chk++;
      if (busy_b !== 1'b1) begin
         n_fail++; $display("FAIL abort_busy: busy %b mid-transfer, required 1", busy_b);
      end
      resetn = 1'b0;
      #1;
      n_chk++;
      if ({sdo_b, ld_b, busy_b, done_b, rd_b, raddr_b} !== '0) begin
         n_fail++; $display("FAIL abort_outputs: %b right after reset, required all 0", {sdo_b, ld_b, busy_b, done_b, rd_b, raddr_b});
      end
      repeat (3) @(negedge clk);
      #2 resetn = 1'b1;
      repeat (LB + 60) @(negedge clk);
      n_chk++;
      if (ld_pulses_b - p0 != AUTO) begin
         n_fail++; $display("FAIL abort_no_load: %0d load pulses, required %0d", ld_pulses_b - p0, AUTO);
      end
      fill_push(); run_big("post_abort", 0, 1'b0);
   endtask

   task automatic test_edges();
      n_chk++;
      if (edge_bad != 0) begin
         n_fail++; $display("FAIL posedge_change: %0d chain output changes while clock high, required 0", edge_bad);
      end
      n_chk++;
      if (ld_bad != 0) begin
         n_fail++; $display("FAIL load_width: %0d load pulses not one period, required 0", ld_bad);
      end
      n_chk++;
      if (ld_pulses_b != 6 + 2 * AUTO || ld_pulses_s != 1 + 2 * AUTO) begin
         n_fail++; $display("FAIL load_totals: big %0d small %0d, required %0d and %0d", ld_pulses_b, ld_pulses_s, 6 + 2 * AUTO, 1 + 2 * AUTO);
      end
   endtask

   initial begin
      foreach (mem_b[k]) mem_b[k] = P'($urandom);
      mem_s[1] = 10'h3FF;
      mem_s[0] = 10'h001;
      test_reset();
      test_autostart();
      test_basic_small();
      test_random();
      test_start_ignored();
      test_back_to_back();
      test_abort();
      test_edges();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
